// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic matrix-multiply engine.
//   state_t   : control FSM states
//   clog2     : ceiling log2, never smaller than 1, for index/counter widths
//   flush_len : number of zero-injection cycles needed to drain the array
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // The last operand pair reaches PE(n-1,n-1) 2n-2 edges after it enters
  // the skew lines; one extra cycle keeps DRAIN strictly after that MAC.
  function automatic int flush_len(input int dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/systolic_mac_pe.sv
// One processing element of the output-stationary array.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous accumulator clear (start of a non-accumulating tile)
//   a_in/b_in  : signed operands from the west / north neighbour
//   a_out/b_out: the same operands, registered, forwarded east / south
//   acc        : running signed sum of a_in*b_in, wraps modulo 2^acc_width
module systolic_mac_pe
  import systolic_pkg::*;
#(
  parameter int data_width = 8,
  parameter int acc_width  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic signed [data_width-1:0] a_in,
  input  logic signed [data_width-1:0] b_in,
  output logic signed [data_width-1:0] a_out,
  output logic signed [data_width-1:0] b_out,
  output logic signed [acc_width-1:0]  acc
);

  localparam int PW = 2 * data_width;

  logic signed [data_width-1:0] a_reg;
  logic signed [data_width-1:0] b_reg;
  logic signed [acc_width-1:0]  acc_reg;
  logic signed [PW-1:0]         prod;

  // Operands are widened (sign-extended) before the multiply so the full
  // signed product is formed, then sign-extended again to the accumulator.
  assign prod = PW'(a_in) * PW'(b_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
    end else begin
      a_reg <= a_in;
      b_reg <= b_in;
      if (clr) begin
        acc_reg <= '0;
      end else begin
        acc_reg <= acc_reg + acc_width'(prod);
      end
    end
  end

  assign a_out = a_reg;
  assign b_out = b_reg;
  assign acc   = acc_reg;

endmodule

// File: rtl/systolic_mm_engine.sv
// n x n output-stationary systolic matrix-multiply engine.
// Takes unskewed per-k operand vectors, skews them internally, computes
// C = A*B (or C += A*B) over a programmable inner dimension and drains C
// one row per handshake.
//   clk, rst           : clock, synchronous active-high reset
//   start, cfg_k,
//   cfg_acc            : job request and its configuration (sampled in IDLE)
//   in_valid/in_ready  : operand beat handshake; a_vec lane i = A[i][k],
//                        b_vec lane j = B[k][j]
//   out_valid/out_ready: result row handshake; out_row lane j =
//                        C[out_row_idx][j]
//   busy               : engine not idle
//   done               : one-cycle pulse after the last row is accepted
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter int n          = 8,
  parameter int data_width = 8,
  parameter int acc_width  = 32,
  parameter int k_width    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [k_width-1:0]        cfg_k,
  input  logic                      cfg_acc,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [n*data_width-1:0]   a_vec,
  input  logic [n*data_width-1:0]   b_vec,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [n*acc_width-1:0]    out_row,
  output logic [clog2(n)-1:0]       out_row_idx,
  output logic                      busy,
  output logic                      done
);

  localparam int             IW         = clog2(n);
  localparam int             FW         = clog2(flush_len(n) + 1);
  localparam logic [IW-1:0]  LAST_ROW   = IW'(n - 1);
  localparam logic [FW-1:0]  FLUSH_LAST = FW'(flush_len(n) - 1);

  state_t              state_reg, state_next;
  logic [k_width-1:0]  cfg_k_reg, cfg_k_next;
  logic [k_width-1:0]  beat_cnt_reg, beat_cnt_next;
  logic [FW-1:0]       flush_cnt_reg, flush_cnt_next;
  logic [IW-1:0]       row_idx_reg, row_idx_next;
  logic                beat_xfer;
  logic                acc_clr;

  // Only a real transfer puts data into the skew lines; every other cycle
  // (bubbles, FLUSH, idle) feeds zeros, which leave the sums untouched.
  assign beat_xfer = (state_reg == ST_LOAD) && in_valid;
  assign acc_clr   = (state_reg == ST_IDLE) && start && !cfg_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cfg_k_reg     <= '0;
      beat_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
      row_idx_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cfg_k_reg     <= cfg_k_next;
      beat_cnt_reg  <= beat_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
      row_idx_reg   <= row_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cfg_k_next     = cfg_k_reg;
    beat_cnt_next  = beat_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    row_idx_next   = row_idx_reg;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    done           = 1'b0;
    busy           = (state_reg != ST_IDLE);
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          cfg_k_next    = cfg_k;
          beat_cnt_next = '0;
          row_idx_next  = '0;
          state_next    = (cfg_k != '0) ? ST_LOAD : ST_DRAIN;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          beat_cnt_next = beat_cnt_reg + k_width'(1);
          // cfg_k is nonzero here, so cfg_k-1 cannot underflow.
          if (beat_cnt_reg == cfg_k_reg - k_width'(1)) begin
            flush_cnt_next = '0;
            state_next     = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_reg == FLUSH_LAST) begin
          row_idx_next = '0;
          state_next   = ST_DRAIN;
        end else begin
          flush_cnt_next = flush_cnt_reg + FW'(1);
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (row_idx_reg == LAST_ROW) begin
            state_next = ST_DONE;
          end else begin
            row_idx_next = row_idx_reg + IW'(1);
          end
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand mesh: a_h[i][j] enters PE(i,j) from the west, b_v[i][j] from
  // the north. Column n of a_h and row n of b_v are the far-edge outputs.
  logic signed [data_width-1:0] a_h      [n][n+1];
  logic signed [data_width-1:0] b_v      [n+1][n];
  logic signed [acc_width-1:0]  acc_grid [n][n];

  // Skew triangles: lane gi is delayed gi cycles so A[i][k] and B[k][j]
  // meet in PE(i,j) on the same edge.
  genvar gi, gj;
  generate
    for (gi = 0; gi < n; gi++) begin : g_skew
      logic signed [data_width-1:0] a_lane;
      logic signed [data_width-1:0] b_lane;
      assign a_lane = beat_xfer ? a_vec[gi*data_width +: data_width] : '0;
      assign b_lane = beat_xfer ? b_vec[gi*data_width +: data_width] : '0;
      if (gi == 0) begin : g_direct
        assign a_h[gi][0] = a_lane;
        assign b_v[0][gi] = b_lane;
      end else begin : g_delay
        logic signed [data_width-1:0] a_sr [gi];
        logic signed [data_width-1:0] b_sr [gi];
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int s = 0; s < gi; s++) begin
              a_sr[s] <= '0;
              b_sr[s] <= '0;
            end
          end else begin
            a_sr[0] <= a_lane;
            b_sr[0] <= b_lane;
            for (int s = 1; s < gi; s++) begin
              a_sr[s] <= a_sr[s-1];
              b_sr[s] <= b_sr[s-1];
            end
          end
        end
        assign a_h[gi][0] = a_sr[gi-1];
        assign b_v[0][gi] = b_sr[gi-1];
      end
    end

    for (gi = 0; gi < n; gi++) begin : g_row
      for (gj = 0; gj < n; gj++) begin : g_col
        systolic_mac_pe #(
          .data_width (data_width),
          .acc_width  (acc_width)
        ) u_pe (
          .clk   (clk),
          .rst   (rst),
          .clr   (acc_clr),
          .a_in  (a_h[gi][gj]),
          .b_in  (b_v[gi][gj]),
          .a_out (a_h[gi][gj+1]),
          .b_out (b_v[gi+1][gj]),
          .acc   (acc_grid[gi][gj])
        );
      end
    end

    for (gj = 0; gj < n; gj++) begin : g_out
      assign out_row[gj*acc_width +: acc_width] = acc_grid[row_idx_reg][gj];
    end
  endgenerate

  assign out_row_idx = row_idx_reg;

endmodule

// File: tb/tb_systolic_mm_engine.sv
module tb_systolic_mm_engine;
  localparam int N    = 8;
  localparam int DW   = 8;
  localparam int AW   = 32;
  localparam int KW   = 8;
  localparam int KMAX = 16;
  localparam int LIM  = 2000;

  logic              clk = 1'b0;
  logic              rst, start, cfg_acc, in_valid, in_ready;
  logic              out_valid, out_ready, busy, done;
  logic [KW-1:0]     cfg_k;
  logic [N*DW-1:0]   a_vec, b_vec;
  logic [N*AW-1:0]   out_row;
  logic [2:0]        out_row_idx;

  always #5 clk = ~clk;

  systolic_mm_engine #(.n(N), .data_width(DW), .acc_width(AW), .k_width(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_acc(cfg_acc),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Operand matrices, reference result and captured result.
  logic signed [DW-1:0] a_m [N][KMAX];
  logic signed [DW-1:0] b_m [KMAX][N];
  int                   ref_c [N][N];
  logic [AW-1:0]        got [N][N];
  int                   seen [N];

  // Observations gathered by run_op.
  logic timeout, order_ok, stable_ok, busy_start, ready_start;
  logic ready_after_last, done_at_expected, busy_after_done;
  int   lat, ready_gaps, done_cnt;

  task automatic fill_plan();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) a_m[i][k] = DW'(8*i + k + 1);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < N; j++) b_m[k][j] = DW'(64 - (8*k + j));
  endtask

  task automatic drive_beat(input logic v, input int kk);
    in_valid = v;
    for (int i = 0; i < N; i++) begin
      a_vec[i*DW +: DW] = v ? a_m[i][kk] : DW'($urandom);
      b_vec[i*DW +: DW] = v ? b_m[kk][i] : DW'($urandom);
    end
  endtask

  // Runs one complete job: start, K beats (with bubble pattern), flush,
  // drain (with optional hold of one row), done. Updates the reference
  // model: C = sum over k of A[i][k]*B[k][j], optionally added to old C.
  task automatic run_op(input int k, input logic acc, input int mode,
                        input int bp_row, input int bp_len);
    int beats, cyc, row_next, bp_left;
    logic tog, valid_s, ready_s;
    logic [2:0] cur_idx, hold_idx;
    logic [N*AW-1:0] cur_row, hold_row;
    timeout = 0; order_ok = 1; stable_ok = 1; done_cnt = 0; ready_gaps = 0;
    for (int r = 0; r < N; r++) seen[r] = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int kk = 0; kk < k; kk++) s += int'(a_m[i][kk]) * int'(b_m[kk][j]);
        ref_c[i][j] = acc ? ref_c[i][j] + s : s;
      end
    start = 1; cfg_k = KW'(k); cfg_acc = acc;
    @(posedge clk); #1;
    start = 0;
    busy_start = busy; ready_start = in_ready;
    beats = 0; cyc = 0; tog = 0;
    while (beats < k && cyc < LIM) begin
      ready_s = in_ready;
      if (!ready_s) ready_gaps++;
      if (done) done_cnt++;
      case (mode)
        0: valid_s = 1'b1;
        1: valid_s = tog;
        default: valid_s = 1'($urandom_range(0, 1));
      endcase
      tog = !tog;
      drive_beat(valid_s, beats);
      @(posedge clk); #1;
      if (valid_s && ready_s) beats++;
      cyc++;
    end
    if (cyc >= LIM) timeout = 1;
    drive_beat(1'b0, 0);
    ready_after_last = in_ready;
    lat = 1;
    while (!out_valid && lat < LIM) begin
      if (done) done_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= LIM) timeout = 1;
    row_next = 0; bp_left = bp_len; cyc = 0;
    hold_idx = '0; hold_row = '0;
    while (row_next < N && cyc < LIM) begin
      valid_s = out_valid; cur_idx = out_row_idx; cur_row = out_row;
      if (done) done_cnt++;
      if (bp_left > 0 && bp_left < bp_len && !(valid_s && cur_idx == hold_idx))
        stable_ok = 0;
      if (valid_s && int'(cur_idx) == bp_row && bp_left > 0) begin
        if (bp_left == bp_len) begin
          hold_idx = cur_idx; hold_row = cur_row;
        end else if (cur_idx !== hold_idx || cur_row !== hold_row) begin
          stable_ok = 0;
        end
        bp_left--;
        out_ready = 0;
      end else begin
        out_ready = (mode == 2) ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(posedge clk);
      if (valid_s && out_ready) begin
        if (int'(cur_idx) != row_next) order_ok = 0;
        seen[cur_idx]++;
        for (int j = 0; j < N; j++) got[cur_idx][j] = cur_row[j*AW +: AW];
        row_next++;
      end
      #1;
      cyc++;
    end
    if (cyc >= LIM) timeout = 1;
    out_ready = 1;
    done_at_expected = done;
    if (done) done_cnt++;
    @(posedge clk); #1;
    if (done) done_cnt++;
    busy_after_done = busy;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; cfg_k = '0; cfg_acc = 0; in_valid = 0;
    a_vec = '0; b_vec = '0; out_ready = 1;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) ref_c[i][j] = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (out_row_idx !== 3'd0) begin errors++; $display("FAIL reset_out_row_idx got %0d expected 0", out_row_idx); end
    checks++; if (out_row !== '0) begin errors++; $display("FAIL reset_out_row got %h expected 0", out_row); end
    rst = 0;
    $display("reset: done");
  endtask

  task automatic test_basic();
    fill_plan();
    run_op(8, 0, 0, -1, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b expected 0", timeout); end
    checks++; if (busy_start !== 1'b1 || ready_start !== 1'b1) begin errors++; $display("FAIL basic_after_start busy=%b in_ready=%b expected 1 1", busy_start, ready_start); end
    checks++; if (lat != 16) begin errors++; $display("FAIL basic_latency got %0d expected 16", lat); end
    checks++; if (ready_after_last !== 1'b0) begin errors++; $display("FAIL basic_ready_after_last got %b expected 0", ready_after_last); end
    checks++; if (got[0][0] !== 32'd960) begin errors++; $display("FAIL basic_c00 got %0d expected 960", $signed(got[0][0])); end
    checks++; if (got[0][7] !== 32'd708) begin errors++; $display("FAIL basic_c07 got %0d expected 708", $signed(got[0][7])); end
    checks++; if (got[7][0] !== 32'd17088) begin errors++; $display("FAIL basic_c70 got %0d expected 17088", $signed(got[7][0])); end
    checks++; if (got[7][7] !== 32'd13700) begin errors++; $display("FAIL basic_c77 got %0d expected 13700", $signed(got[7][7])); end
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      checks++;
      if (got[i][j] !== AW'(ref_c[i][j])) begin errors++; $display("FAIL basic_c[%0d][%0d] got %0d expected %0d", i, j, $signed(got[i][j]), ref_c[i][j]); end
    end
    checks++; if (order_ok !== 1'b1) begin errors++; $display("FAIL basic_order got %b expected 1", order_ok); end
    checks++; if (done_cnt != 1 || done_at_expected !== 1'b1) begin errors++; $display("FAIL basic_done count=%0d at_expected=%b expected 1 1", done_cnt, done_at_expected); end
    checks++; if (busy_after_done !== 1'b0) begin errors++; $display("FAIL basic_busy_after_done got %b expected 0", busy_after_done); end
    $display("basic: K=8 latency=%0d C00=%0d C77=%0d", lat, $signed(got[0][0]), $signed(got[7][7]));
  endtask

  task automatic test_bubbles();
    fill_plan();
    run_op(8, 0, 1, -1, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL bubbles_timeout got %b expected 0", timeout); end
    checks++; if (ready_gaps != 0 || ready_after_last !== 1'b0) begin errors++; $display("FAIL bubbles_in_ready gaps=%0d after_last=%b expected 0 0", ready_gaps, ready_after_last); end
    checks++; if (got[0][0] !== 32'd960) begin errors++; $display("FAIL bubbles_c00 got %0d expected 960", $signed(got[0][0])); end
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      checks++;
      if (got[i][j] !== AW'(ref_c[i][j])) begin errors++; $display("FAIL bubbles_c[%0d][%0d] got %0d expected %0d", i, j, $signed(got[i][j]), ref_c[i][j]); end
    end
    $display("bubbles: K=8 C00=%0d", $signed(got[0][0]));
  endtask

  task automatic test_accumulate();
    fill_plan();
    run_op(8, 0, 0, -1, 0);
    run_op(8, 1, 0, -1, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL acc_timeout got %b expected 0", timeout); end
    checks++; if (got[0][0] !== 32'd1920) begin errors++; $display("FAIL acc_c00 got %0d expected 1920", $signed(got[0][0])); end
    checks++; if (got[7][0] !== 32'd34176) begin errors++; $display("FAIL acc_c70 got %0d expected 34176", $signed(got[7][0])); end
    checks++; if (got[7][7] !== 32'd27400) begin errors++; $display("FAIL acc_c77 got %0d expected 27400", $signed(got[7][7])); end
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      checks++;
      if (got[i][j] !== AW'(ref_c[i][j])) begin errors++; $display("FAIL acc_c[%0d][%0d] got %0d expected %0d", i, j, $signed(got[i][j]), ref_c[i][j]); end
    end
    $display("accumulate: C00=%0d C77=%0d", $signed(got[0][0]), $signed(got[7][7]));
  endtask

  task automatic test_backpressure();
    fill_plan();
    run_op(8, 0, 0, 3, 5);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b expected 0", timeout); end
    checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL bp_row3_stable got %b expected 1", stable_ok); end
    checks++; if (order_ok !== 1'b1) begin errors++; $display("FAIL bp_order got %b expected 1", order_ok); end
    for (int r = 0; r < N; r++) begin
      checks++;
      if (seen[r] != 1) begin errors++; $display("FAIL bp_row%0d_count got %0d expected 1", r, seen[r]); end
    end
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      checks++;
      if (got[i][j] !== AW'(ref_c[i][j])) begin errors++; $display("FAIL bp_c[%0d][%0d] got %0d expected %0d", i, j, $signed(got[i][j]), ref_c[i][j]); end
    end
    $display("backpressure: row 3 held 5 cycles, stable=%b order=%b", stable_ok, order_ok);
  endtask

  task automatic test_signed_zero_k();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) begin
        a_m[i][k] = 8'hFF;
        b_m[k][i] = 8'sd127;
      end
    run_op(4, 0, 0, -1, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL signed_timeout got %b expected 0", timeout); end
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      checks++;
      if (got[i][j] !== 32'hFFFFFE04) begin errors++; $display("FAIL signed_c[%0d][%0d] got %h expected fffffe04", i, j, got[i][j]); end
    end
    $display("signed: K=4 C00=%0d", $signed(got[0][0]));
    run_op(0, 0, 0, -1, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL zero_k_timeout got %b expected 0", timeout); end
    checks++; if (lat != 1) begin errors++; $display("FAIL zero_k_latency got %0d expected 1", lat); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_k_done count got %0d expected 1", done_cnt); end
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      checks++;
      if (got[i][j] !== 32'd0) begin errors++; $display("FAIL zero_k_c[%0d][%0d] got %0d expected 0", i, j, $signed(got[i][j])); end
    end
    $display("zero_k: latency=%0d rows=%0d", lat, seen[0] + seen[7]);
  endtask

  task automatic test_reset_mid_load();
    fill_plan();
    start = 1; cfg_k = 8'd8; cfg_acc = 0;
    @(posedge clk); #1;
    start = 0;
    for (int kk = 0; kk < 3; kk++) begin
      drive_beat(1'b1, kk);
      @(posedge clk); #1;
    end
    drive_beat(1'b0, 0);
    rst = 1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b expected 0", in_ready); end
    rst = 0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) ref_c[i][j] = 0;
    run_op(8, 1, 0, -1, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL midrst_timeout got %b expected 0", timeout); end
    checks++; if (got[0][0] !== 32'd960) begin errors++; $display("FAIL midrst_c00 got %0d expected 960", $signed(got[0][0])); end
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      checks++;
      if (got[i][j] !== AW'(ref_c[i][j])) begin errors++; $display("FAIL midrst_c[%0d][%0d] got %0d expected %0d", i, j, $signed(got[i][j]), ref_c[i][j]); end
    end
    $display("reset_mid_load: C00=%0d after acc run", $signed(got[0][0]));
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int k, bpr, bpl;
      logic acc;
      k   = $urandom_range(1, KMAX);
      acc = 1'($urandom_range(0, 1));
      bpr = $urandom_range(0, N - 1);
      bpl = $urandom_range(1, 4);
      for (int i = 0; i < N; i++)
        for (int kk = 0; kk < KMAX; kk++) begin
          a_m[i][kk] = DW'($urandom);
          b_m[kk][i] = DW'($urandom);
        end
      run_op(k, acc, 2, bpr, bpl);
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout got %b expected 0", it, timeout); end
      checks++; if (order_ok !== 1'b1 || stable_ok !== 1'b1) begin errors++; $display("FAIL rand%0d_drain order=%b stable=%b expected 1 1", it, order_ok, stable_ok); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand%0d_done count got %0d expected 1", it, done_cnt); end
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
        checks++;
        if (got[i][j] !== AW'(ref_c[i][j])) begin errors++; $display("FAIL rand%0d_c[%0d][%0d] got %0d expected %0d", it, i, j, $signed(got[i][j]), ref_c[i][j]); end
      end
      $display("random %0d: K=%0d acc=%b hold_row=%0d C00=%0d", it, k, acc, bpr, $signed(got[0][0]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_accumulate();
    test_backpressure();
    test_signed_zero_k();
    test_reset_mid_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
